// File: rtl/tour_reader.sv
// rtl/tour_reader.sv - tour read-out engine: snapshots a tour, streams its cities and sums the closed Manhattan length
module tour_reader #(
    parameter int N = 64,
    parameter int W = 32,
    localparam int L = $clog2(N)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [W-1:0] path_i [N],
    input  logic [W-1:0] xs_i [N],
    input  logic [W-1:0] ys_i [N],
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [L-1:0] out_idx_o,
    output logic [L-1:0] out_city_o,
    output logic [W-1:0] out_x_o,
    output logic [W-1:0] out_y_o,
    output logic         out_last_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] tour_len_o,
    output logic         err_o
);
    typedef enum logic [2:0] {IDLE, CAPTURE, EMIT, CLOSE, DONE} state_t;
    localparam logic [L-1:0] LAST = L'(N - 1);

    state_t       state_q;
    logic [L-1:0] snap_q [N];
    logic [N-1:0] seen_q;
    logic [W-1:0] prev_x_q, prev_y_q, first_x_q, first_y_q;
    logic [W-1:0] tour_len_q;
    logic         err_q, done_q, busy_q, out_valid_q, out_last_q;
    logic [L-1:0] out_idx_q, out_city_q;
    logic [W-1:0] out_x_q, out_y_q;

    logic         range_err;
    logic [L-1:0] k_nxt;
    logic [L-1:0] city_nxt;
    logic [L-1:0] city_first;
    logic [W-1:0] edge_len, close_len;

    function automatic logic [W-1:0] absdiff(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    always_comb begin
        range_err = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (path_i[i][W-1:L] != '0) range_err = 1'b1;
        end
    end

    assign k_nxt      = out_idx_q + 1'b1;
    assign city_nxt   = snap_q[k_nxt];
    assign city_first = path_i[0][L-1:0];
    assign edge_len   = absdiff(out_x_q, prev_x_q) + absdiff(out_y_q, prev_y_q);
    assign close_len  = absdiff(prev_x_q, first_x_q) + absdiff(prev_y_q, first_y_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            for (int i = 0; i < N; i++) snap_q[i] <= '0;
            seen_q      <= '0;
            prev_x_q    <= '0;
            prev_y_q    <= '0;
            first_x_q   <= '0;
            first_y_q   <= '0;
            tour_len_q  <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
            out_city_q  <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q <= CAPTURE;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CAPTURE: begin
                    for (int i = 0; i < N; i++) snap_q[i] <= path_i[i][L-1:0];
                    tour_len_q <= '0;
                    seen_q     <= '0;
                    out_idx_q  <= '0;
                    if (range_err) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        // First beat comes straight from the inputs; the snapshot lands on this same edge.
                        err_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_city_q  <= city_first;
                        out_x_q     <= xs_i[city_first];
                        out_y_q     <= ys_i[city_first];
                        out_last_q  <= (LAST == '0);
                        state_q     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready_i) begin
                        if (seen_q[out_city_q]) err_q <= 1'b1;
                        seen_q[out_city_q] <= 1'b1;
                        if (out_idx_q != '0) begin
                            tour_len_q <= tour_len_q + edge_len;
                        end else begin
                            first_x_q <= out_x_q;
                            first_y_q <= out_y_q;
                        end
                        prev_x_q <= out_x_q;
                        prev_y_q <= out_y_q;
                        if (out_idx_q == LAST) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            state_q     <= CLOSE;
                        end else begin
                            out_idx_q  <= k_nxt;
                            out_city_q <= city_nxt;
                            out_x_q    <= xs_i[city_nxt];
                            out_y_q    <= ys_i[city_nxt];
                            out_last_q <= (k_nxt == LAST);
                        end
                    end
                end
                CLOSE: begin
                    tour_len_q <= tour_len_q + close_len;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    state_q    <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_idx_o   = out_idx_q;
    assign out_city_o  = out_city_q;
    assign out_x_o     = out_x_q;
    assign out_y_o     = out_y_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign tour_len_o  = tour_len_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_tour_reader.sv
// tb/tb_tour_reader.sv - directed table-driven bench for tour_reader
module tb_tour_reader;
    localparam int N = 64;
    localparam int W = 32;
    localparam int L = 6;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] path [N];
    logic [W-1:0] xs [N];
    logic [W-1:0] ys [N];
    logic         out_valid, out_ready, out_last, busy, done, err;
    logic [L-1:0] out_idx, out_city;
    logic [W-1:0] out_x, out_y, tour_len;

    int checks = 0;
    int failures = 0;

    tour_reader #(.N(N), .W(W)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start),
        .path_i(path), .xs_i(xs), .ys_i(ys),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_idx_o(out_idx), .out_city_o(out_city),
        .out_x_o(out_x), .out_y_o(out_y), .out_last_o(out_last),
        .busy_o(busy), .done_o(done), .tour_len_o(tour_len), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          pmode;     // 0 identity, 1 reverse, 2 dup at 5, 3 range error at 10
        int          cmode;     // 0 x=i y=0, 1 x=i y=2i, 2 x alternating 0/2^31
        bit          rdy_alt;
        bit          mid_start;
        int          exp_beats;
        int          exp_base;  // done latency with no stalls
        logic [31:0] exp_len;
        bit          exp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setup(input int pmode, input int cmode);
        for (int i = 0; i < N; i++) begin
            path[i] = (pmode == 1) ? 32'(N - 1 - i) : 32'(i);
            xs[i] = (cmode == 2) ? ((i % 2 == 1) ? 32'h8000_0000 : 32'h0) : 32'(i);
            ys[i] = (cmode == 1) ? 32'(2 * i) : 32'h0;
        end
        if (pmode == 2) path[5] = 32'd4;
        if (pmode == 3) path[10] = 32'd64;
    endtask

    task automatic run_case(input vec_t v, input bit skip_start, input bit chain);
        int  rel, bi, stalls, done_rel;
        bit  prev_stall;
        logic [L-1:0] c;
        if (!skip_start) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        rel = 1;
        bi = 0;
        stalls = 0;
        done_rel = -1;
        prev_stall = 1'b0;
        check("capture_state", {busy, out_valid, done}, 3'b100);
        while (done_rel < 0 && rel < 400) begin
            @(negedge clk);
            rel++;
            out_ready = v.rdy_alt ? rel[0] : 1'b1;
            start = (v.mid_start && bi == 10);
            if (prev_stall) check("hold_valid", out_valid, 1'b1);
            if (out_valid) begin
                c = path[bi][L-1:0];
                check($sformatf("beat%0d", bi), {out_idx, out_city, out_x, out_y, out_last},
                      {6'(bi), c, xs[c], ys[c], bi == N - 1});
                prev_stall = !out_ready;
                if (out_ready) bi++; else stalls++;
            end else begin
                prev_stall = 1'b0;
            end
            if (done) done_rel = rel;
        end
        start = 1'b0;
        out_ready = 1'b1;
        check("done_seen", done_rel >= 0, 1'b1);
        check("beats", 32'(bi), 32'(v.exp_beats));
        check("done_latency", 32'(done_rel), 32'(v.exp_base + stalls));
        if (v.rdy_alt) check("stalls_happened", stalls > 0, 1'b1);
        check("result", {busy, tour_len, err}, {1'b0, v.exp_len, v.exp_err});
        if (chain) begin
            start = 1'b1;
        end else begin
            @(negedge clk);
            check("done_pulse", {done, busy, tour_len, err}, {1'b0, 1'b0, v.exp_len, v.exp_err});
        end
    endtask

    initial begin
        out_ready = 1'b1;
        vecs[0] = '{0, 0, 0, 0, 64, 67, 32'd126, 0};
        vecs[1] = '{0, 0, 1, 0, 64, 67, 32'd126, 0};
        vecs[2] = '{2, 0, 0, 0, 64, 67, 32'd126, 1};
        vecs[3] = '{3, 0, 0, 0, 0, 2, 32'd0, 1};
        vecs[4] = '{1, 1, 0, 1, 64, 67, 32'd378, 0};
        vecs[5] = '{0, 2, 1, 0, 64, 67, 32'd0, 0};
        setup(0, 0);
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, out_valid, out_last, done, err, out_idx, out_city, out_x, out_y, tour_len}, '0);
        rst_ni = 1'b1;
        @(negedge clk);
        check("idle_outputs", {busy, out_valid, done, tour_len}, '0);

        for (int i = 0; i < 6; i++) begin
            setup(vecs[i].pmode, vecs[i].cmode);
            run_case(vecs[i], 1'b0, 1'b0);
        end

        // back-to-back: start held through DONE re-captures immediately
        setup(0, 0);
        run_case(vecs[0], 1'b0, 1'b1);
        run_case(vecs[0], 1'b1, 1'b0);

        // asynchronous reset in the middle of the stream
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (31) @(negedge clk);
        check("beat30_before_reset", {out_valid, out_idx}, {1'b1, 6'd30});
        #2 rst_ni = 1'b0;
        #1 check("async_reset", {busy, out_valid, out_last, done, err, out_idx, out_city, out_x, out_y, tour_len}, '0);
        @(negedge clk);
        rst_ni = 1'b1;
        run_case(vecs[0], 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
